// File: rtl/dps_req_arbiter.sv
// Round-robin two-port front end for the single DPS request port.
// One transaction in flight; read responses return to the owning port, with a watchdog on reads.
module dps_req_arbiter #(
    parameter logic [15:0] P_TIMEOUT = 16'd1024
) (
    input  logic        iCLOCK,
    input  logic        inRESET,
    input  logic        iREQ0_VALID,
    output logic        oREQ0_BUSY,
    input  logic        iREQ0_RW,
    input  logic [31:0] iREQ0_ADDR,
    input  logic [31:0] iREQ0_DATA,
    output logic        oREQ0_VALID,
    output logic [31:0] oREQ0_DATA,
    input  logic        iREQ1_VALID,
    output logic        oREQ1_BUSY,
    input  logic        iREQ1_RW,
    input  logic [31:0] iREQ1_ADDR,
    input  logic [31:0] iREQ1_DATA,
    output logic        oREQ1_VALID,
    output logic [31:0] oREQ1_DATA,
    output logic        oDPS_REQ,
    input  logic        iDPS_BUSY,
    output logic        oDPS_RW,
    output logic [31:0] oDPS_ADDR,
    output logic [31:0] oDPS_DATA,
    input  logic        iDPS_VALID,
    input  logic [31:0] iDPS_DATA,
    output logic        oTIMEOUT
);
    // state   | meaning
    // IDLE    | waiting for a request; only state that accepts
    // ISSUE   | request presented to DPS until it is not busy
    // RD_WAIT | read issued, waiting for data or watchdog expiry
    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_RD_WAIT} state_t;

    state_t      state_q, state_d;
    logic        owner_q, owner_d;
    logic        last_q, last_d;
    logic        rw_q, rw_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [15:0] cnt_q, cnt_d;
    logic        rsp0_valid_q, rsp0_valid_d;
    logic        rsp1_valid_q, rsp1_valid_d;
    logic [31:0] rsp0_data_q, rsp0_data_d;
    logic [31:0] rsp1_data_q, rsp1_data_d;
    logic        tout_q, tout_d;

    logic        idle;
    logic        acc0, acc1;
    logic        rsp_fire;
    logic [31:0] rsp_word;

    // On a tie the port that was not granted last wins.
    assign idle       = (state_q == ST_IDLE);
    assign oREQ0_BUSY = !idle || (iREQ1_VALID && !last_q);
    assign oREQ1_BUSY = !idle || (iREQ0_VALID && last_q);
    assign acc0       = iREQ0_VALID && !oREQ0_BUSY;
    assign acc1       = iREQ1_VALID && !oREQ1_BUSY;

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_d       = last_q;
        rw_d         = rw_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        cnt_d        = cnt_q;
        tout_d       = 1'b0;
        rsp_fire     = 1'b0;
        rsp_word     = 32'h0;
        case (state_q)
            ST_IDLE: begin
                if (acc0 || acc1) begin
                    owner_d = acc1;
                    last_d  = acc1;
                    rw_d    = acc1 ? iREQ1_RW   : iREQ0_RW;
                    addr_d  = acc1 ? iREQ1_ADDR : iREQ0_ADDR;
                    wdata_d = acc1 ? iREQ1_DATA : iREQ0_DATA;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (!iDPS_BUSY) begin
                    if (rw_q) begin
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d   = 16'd0;
                        state_d = ST_RD_WAIT;
                    end
                end
            end
            ST_RD_WAIT: begin
                // Real data beats the watchdog when both land in the same cycle.
                if (iDPS_VALID) begin
                    rsp_fire = 1'b1;
                    rsp_word = iDPS_DATA;
                    state_d  = ST_IDLE;
                end else if (cnt_q == P_TIMEOUT - 16'd1) begin
                    rsp_fire = 1'b1;
                    rsp_word = 32'hFFFF_FFFF;
                    tout_d   = 1'b1;
                    state_d  = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        rsp0_valid_d = rsp_fire && !owner_q;
        rsp1_valid_d = rsp_fire && owner_q;
        rsp0_data_d  = (rsp_fire && !owner_q) ? rsp_word : rsp0_data_q;
        rsp1_data_d  = (rsp_fire && owner_q)  ? rsp_word : rsp1_data_q;
    end

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            state_q      <= ST_IDLE;
            owner_q      <= 1'b0;
            last_q       <= 1'b1;
            rw_q         <= 1'b0;
            addr_q       <= 32'h0;
            wdata_q      <= 32'h0;
            cnt_q        <= 16'd0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            rsp0_data_q  <= 32'h0;
            rsp1_data_q  <= 32'h0;
            tout_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_q       <= last_d;
            rw_q         <= rw_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            cnt_q        <= cnt_d;
            rsp0_valid_q <= rsp0_valid_d;
            rsp1_valid_q <= rsp1_valid_d;
            rsp0_data_q  <= rsp0_data_d;
            rsp1_data_q  <= rsp1_data_d;
            tout_q       <= tout_d;
        end
    end

    assign oDPS_REQ    = (state_q == ST_ISSUE);
    assign oDPS_RW     = rw_q;
    assign oDPS_ADDR   = addr_q;
    assign oDPS_DATA   = wdata_q;
    assign oREQ0_VALID = rsp0_valid_q;
    assign oREQ1_VALID = rsp1_valid_q;
    assign oREQ0_DATA  = rsp0_data_q;
    assign oREQ1_DATA  = rsp1_data_q;
    assign oTIMEOUT    = tout_q;

endmodule

// File: tb/tb_dps_req_arbiter.sv
// Scoreboard bench for dps_req_arbiter: directed requests, a small DPS responder model,
// and monitors that check each DPS transfer and each requester response against queued expectations.
module tb_dps_req_arbiter;
    localparam logic [15:0] P_TO = 16'd4;

    typedef struct {
        logic        rw;
        logic [31:0] addr;
        logic [31:0] data;
    } xfer_t;

    typedef struct {
        logic        port;
        logic [31:0] data;
        logic        tout;
    } rsp_t;

    logic        iCLOCK = 1'b0;
    logic        inRESET;
    logic        iREQ0_VALID, iREQ0_RW, iREQ1_VALID, iREQ1_RW;
    logic [31:0] iREQ0_ADDR, iREQ0_DATA, iREQ1_ADDR, iREQ1_DATA;
    logic        oREQ0_BUSY, oREQ1_BUSY, oREQ0_VALID, oREQ1_VALID;
    logic [31:0] oREQ0_DATA, oREQ1_DATA;
    logic        oDPS_REQ, iDPS_BUSY, oDPS_RW, iDPS_VALID, oTIMEOUT;
    logic [31:0] oDPS_ADDR, oDPS_DATA, iDPS_DATA;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int handoff_cyc = 0;
    logic prev_dps_valid = 1'b0;

    int busy_cnt = 0;
    int rsp_delay = 0;
    int rsp_cnt = 0;
    logic [31:0] rsp_word = 32'h0;

    xfer_t exp_xfer[$];
    rsp_t  exp_rsp[$];

    dps_req_arbiter #(.P_TIMEOUT(P_TO)) dut (
        .iCLOCK(iCLOCK), .inRESET(inRESET),
        .iREQ0_VALID(iREQ0_VALID), .oREQ0_BUSY(oREQ0_BUSY), .iREQ0_RW(iREQ0_RW),
        .iREQ0_ADDR(iREQ0_ADDR), .iREQ0_DATA(iREQ0_DATA),
        .oREQ0_VALID(oREQ0_VALID), .oREQ0_DATA(oREQ0_DATA),
        .iREQ1_VALID(iREQ1_VALID), .oREQ1_BUSY(oREQ1_BUSY), .iREQ1_RW(iREQ1_RW),
        .iREQ1_ADDR(iREQ1_ADDR), .iREQ1_DATA(iREQ1_DATA),
        .oREQ1_VALID(oREQ1_VALID), .oREQ1_DATA(oREQ1_DATA),
        .oDPS_REQ(oDPS_REQ), .iDPS_BUSY(iDPS_BUSY), .oDPS_RW(oDPS_RW),
        .oDPS_ADDR(oDPS_ADDR), .oDPS_DATA(oDPS_DATA),
        .iDPS_VALID(iDPS_VALID), .iDPS_DATA(iDPS_DATA), .oTIMEOUT(oTIMEOUT)
    );

    always #5 iCLOCK = ~iCLOCK;
    always @(posedge iCLOCK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge iCLOCK);
            #1;
        end
    endtask

    task automatic set_req(input int p, input logic v, input logic rw,
                           input logic [31:0] a, input logic [31:0] d);
        if (p == 0) begin
            iREQ0_VALID = v; iREQ0_RW = rw; iREQ0_ADDR = a; iREQ0_DATA = d;
        end else begin
            iREQ1_VALID = v; iREQ1_RW = rw; iREQ1_ADDR = a; iREQ1_DATA = d;
        end
    endtask

    task automatic push_xfer(input logic rw, input logic [31:0] a, input logic [31:0] d);
        xfer_t x;
        x.rw = rw; x.addr = a; x.data = d;
        exp_xfer.push_back(x);
    endtask

    task automatic push_rsp(input logic p, input logic [31:0] d, input logic t);
        rsp_t r;
        r.port = p; r.data = d; r.tout = t;
        exp_rsp.push_back(r);
    endtask

    // Returns #1 after the accepting edge, i.e. in the first ISSUE cycle.
    task automatic do_req(input int p, input logic rw, input logic [31:0] a, input logic [31:0] d);
        logic acc;
        acc = 1'b0;
        push_xfer(rw, a, d);
        set_req(p, 1'b1, rw, a, d);
        for (int i = 0; i < 50; i++) begin
            @(negedge iCLOCK);
            if ((p == 0) ? !oREQ0_BUSY : !oREQ1_BUSY) begin
                acc = 1'b1;
                break;
            end
        end
        @(posedge iCLOCK);
        #1;
        set_req(p, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("request_accepted", acc, 1'b1);
    endtask

    initial begin : dps_model
        iDPS_BUSY = 1'b0; iDPS_VALID = 1'b0; iDPS_DATA = 32'h0;
        forever begin
            @(posedge iCLOCK);
            #1;
            iDPS_VALID = 1'b0;
            if (rsp_cnt > 0) begin
                rsp_cnt--;
                if (rsp_cnt == 0) begin
                    iDPS_VALID = 1'b1;
                    iDPS_DATA  = rsp_word;
                end
            end
            iDPS_BUSY = 1'b0;
            if (oDPS_REQ) begin
                if (busy_cnt > 0) begin
                    iDPS_BUSY = 1'b1;
                    busy_cnt--;
                end else if (!oDPS_RW) begin
                    rsp_cnt = rsp_delay;
                end
            end
        end
    end

    initial begin : xfer_mon
        xfer_t x;
        forever begin
            @(negedge iCLOCK);
            if (inRESET && oDPS_REQ && !iDPS_BUSY) begin
                if (!oDPS_RW) handoff_cyc = cyc;
                if (exp_xfer.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL xfer_unexpected: got addr %h rw %b, expected no transfer", oDPS_ADDR, oDPS_RW);
                end else begin
                    x = exp_xfer.pop_front();
                    chk("xfer_rw", oDPS_RW, x.rw);
                    chk("xfer_addr", oDPS_ADDR, x.addr);
                    chk("xfer_data", oDPS_DATA, x.data);
                end
            end
        end
    end

    initial begin : rsp_mon
        rsp_t r;
        forever begin
            @(negedge iCLOCK);
            if (oREQ0_VALID || oREQ1_VALID || oTIMEOUT) begin
                if (exp_rsp.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL rsp_unexpected: got v0=%b v1=%b tout=%b, expected no response",
                             oREQ0_VALID, oREQ1_VALID, oTIMEOUT);
                end else begin
                    r = exp_rsp.pop_front();
                    chk("rsp_valid_port", {oREQ1_VALID, oREQ0_VALID}, r.port ? 2'b10 : 2'b01);
                    chk("rsp_data", r.port ? oREQ1_DATA : oREQ0_DATA, r.data);
                    chk("rsp_timeout_flag", oTIMEOUT, r.tout);
                    if (r.tout) chk("timeout_latency", cyc - handoff_cyc, 32'(P_TO) + 32'd1);
                    else chk("rsp_latency", prev_dps_valid, 1'b1);
                end
            end
            prev_dps_valid = iDPS_VALID;
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL sim_watchdog: got no end of test, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int n;
        int good;
        logic win;
        inRESET = 1'b0;
        set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
        set_req(1, 1'b0, 1'b0, 32'h0, 32'h0);
        #12;
        chk("rst_dps_req", oDPS_REQ, 1'b0);
        chk("rst_dps_rw", oDPS_RW, 1'b0);
        chk("rst_dps_addr", oDPS_ADDR, 32'h0);
        chk("rst_dps_data", oDPS_DATA, 32'h0);
        chk("rst_valids", {oREQ1_VALID, oREQ0_VALID, oTIMEOUT}, 3'b000);
        chk("rst_req0_data", oREQ0_DATA, 32'h0);
        chk("rst_req1_data", oREQ1_DATA, 32'h0);
        chk("rst_busy", {oREQ1_BUSY, oREQ0_BUSY}, 2'b00);
        @(posedge iCLOCK);
        #1;
        inRESET = 1'b1;
        tick(1);

        // both ports request continuously: grants alternate starting with port 0
        set_req(0, 1'b1, 1'b1, 32'h300, 32'hA0);
        set_req(1, 1'b1, 1'b1, 32'h304, 32'hB1);
        win = 1'b0;
        n = 0;
        for (int i = 0; i < 40 && n < 8; i++) begin
            @(negedge iCLOCK);
            if (!oDPS_REQ) begin
                chk("rr_winner_busy", win ? oREQ1_BUSY : oREQ0_BUSY, 1'b0);
                chk("rr_loser_busy", win ? oREQ0_BUSY : oREQ1_BUSY, 1'b1);
                if (win) push_xfer(1'b1, 32'h304, 32'hB1);
                else push_xfer(1'b1, 32'h300, 32'hA0);
                win = !win;
                n++;
            end
        end
        @(posedge iCLOCK);
        #1;
        set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
        set_req(1, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("rr_grant_count", n, 8);
        tick(2);

        // single write, port 0
        do_req(0, 1'b1, 32'h100, 32'h41);
        @(negedge iCLOCK);
        chk("wr_req_t1", oDPS_REQ, 1'b1);
        chk("wr_busy_t1", oREQ0_BUSY, 1'b1);
        tick(1);
        @(negedge iCLOCK);
        chk("wr_req_t2", oDPS_REQ, 1'b0);
        chk("wr_busy_t2", oREQ0_BUSY, 1'b0);
        tick(1);

        // read, port 1, DPS answers three cycles after issue
        rsp_delay = 3;
        rsp_word  = 32'hCAFE_0001;
        push_rsp(1'b1, 32'hCAFE_0001, 1'b0);
        do_req(1, 1'b0, 32'h120, 32'h0);
        tick(8);

        // DPS busy for 5 cycles in ISSUE
        busy_cnt = 5;
        do_req(1, 1'b1, 32'h400, 32'h55);
        good = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge iCLOCK);
            if (oDPS_REQ && oDPS_RW && oDPS_ADDR == 32'h400 && oDPS_DATA == 32'h55) good++;
        end
        chk("busy_hold_cycles", good, 6);
        @(negedge iCLOCK);
        chk("busy_release", oDPS_REQ, 1'b0);
        tick(1);

        // read with no answer: watchdog response, then a new request is accepted
        rsp_delay = 0;
        push_rsp(1'b0, 32'hFFFF_FFFF, 1'b1);
        do_req(0, 1'b0, 32'h500, 32'h0);
        tick(8);
        do_req(1, 1'b1, 32'h504, 32'h77);
        tick(2);

        // answer arrives in the watchdog cycle: real data, no timeout
        rsp_delay = 4;
        rsp_word  = 32'h1234_5678;
        push_rsp(1'b0, 32'h1234_5678, 1'b0);
        do_req(0, 1'b0, 32'h508, 32'h0);
        tick(8);
        chk("req1_data_hold", oREQ1_DATA, 32'hCAFE_0001);

        // reset while in RD_WAIT
        rsp_delay = 0;
        do_req(1, 1'b0, 32'h600, 32'h0);
        tick(2);
        inRESET = 1'b0;
        #1;
        chk("mid_rst_dps_req", oDPS_REQ, 1'b0);
        chk("mid_rst_dps_addr", oDPS_ADDR, 32'h0);
        chk("mid_rst_valids", {oREQ1_VALID, oREQ0_VALID, oTIMEOUT}, 3'b000);
        chk("mid_rst_req0_data", oREQ0_DATA, 32'h0);
        chk("mid_rst_req1_data", oREQ1_DATA, 32'h0);
        chk("mid_rst_busy", {oREQ1_BUSY, oREQ0_BUSY}, 2'b00);
        @(posedge iCLOCK);
        #1;
        inRESET = 1'b1;
        tick(10);

        // first tie after reset goes to port 0
        set_req(0, 1'b1, 1'b1, 32'h700, 32'hC0);
        set_req(1, 1'b1, 1'b1, 32'h704, 32'hC1);
        @(negedge iCLOCK);
        chk("tie_p0_busy", oREQ0_BUSY, 1'b0);
        chk("tie_p1_busy", oREQ1_BUSY, 1'b1);
        push_xfer(1'b1, 32'h700, 32'hC0);
        @(posedge iCLOCK);
        #1;
        set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
        do_req(1, 1'b1, 32'h704, 32'hC1);
        tick(4);

        chk("xfer_queue_empty", exp_xfer.size(), 0);
        chk("rsp_queue_empty", exp_rsp.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
